seq_radix4_multiplier: RTL
==========================

// Module: seq_radix4_multiplier
// PURPOSE
//  Iterative unsigned multiplier, parametrised WIDTH x WIDTH -> 2*WIDTH.
//  Retires 2 multiplier bits per cycle with a radix-4 digit select (0/A/2A/3A).
//  Start/done handshake; sits beside the combinational 4x4 multipliers for
//  operands too wide for a single-cycle array.
// PARAMETERS
//  WIDTH  8  operand width in bits; must be even and >= 2, otherwise elaboration error
//  (derived) N = WIDTH/2  radix-4 digits per operand
// PORTS
//  Clock     in   1          rising-edge clock
//  Reset     in   1          synchronous, active-high
//  iStart    in   1          request; sampled only in IDLE or DONE
//  iA        in   WIDTH      multiplicand; latched when iStart is accepted
//  iB        in   WIDTH      multiplier; latched when iStart is accepted
//  oBusy     out  1          high while in CALC
//  oDone     out  1          one-cycle pulse; oResult is valid
//  oResult   out  2*WIDTH    product; holds until the next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; oBusy=0, oDone=0, oResult=0; internal registers cleared.
//   Reset has priority in every state and aborts CALC with no partial result.
//  States: IDLE -> CALC on iStart.
//   CALC loops until the last digit is done, then goes to DONE.
//   DONE -> CALC if iStart, else IDLE.
//  Accepting a start edge:
//   - latch A = iA and Breg = iB
//   - precompute A3 = 3*A (WIDTH+2 bits)
//   - clear acc (2*WIDTH bits) and cnt
//  Each CALC edge:
//   - d = Breg[1:0]; acc += mult(d) << (2*cnt), where mult = 0/A/2A/3A
//   - Breg >>= 2; cnt++
//   - leave CALC after the edge where cnt==N-1
//  No overflow: the sum is computed at 2*WIDTH bits and the product always fits.
//  Latency: oDone=1 exactly N cycles after the edge that accepted iStart.
//   oResult = acc in the DONE cycle.
//  Back-to-back: iStart in the DONE cycle is accepted.
//   oResult keeps the old product during the new CALC and updates only at the next DONE.
//  iStart while busy (CALC) is ignored; the latched operands do not change.
//  oBusy=1 iff state==CALC. oDone=1 iff state==DONE.
//  iA/iB are don't-care outside the accept edge.
// CONFIGURATION
//  Macro MUL_EARLY_TERM_EN.
//   Defined: CALC also exits to DONE when the shifted Breg == 0.
//    Latency becomes 1..N cycles (1 when iB < 4).
//    oResult is unchanged because the remaining digits are zero.
//   Undefined: fixed latency N regardless of operand values.
// STRUCTURE
//  Package mul_pkg holds:
//   - state encodings ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2
//   - DIGIT_W=2
//   - the cnt width function clog2(N)
//  One sub-module, radix4_digit_mux (combinational):
//   - inputs: A, A3, d
//   - output: WIDTH+2 bit multiple
//  Top level holds the FSM, the accumulator and the shift registers.
// TESTING (WIDTH=8 unless noted)
//  - 0xFF*0xFF: oDone 4 cycles after accept, oResult=0xFE01, oBusy high for 4 cycles.
//  - 0x00*0xAB and 0x37*0x00 -> 0x0000. With MUL_EARLY_TERM_EN, B=0 gives oDone after 1 cycle.
//  - Start 0x12*0x34, pulse iStart with 0x99*0x99 at cycle 2 of CALC
//    -> ignored; oResult=0x03A8.
//  - Back-to-back: 7*9 then iStart during DONE with 0xF0*0x0F
//    -> 0x003F, then 0x0E10 four cycles later; old value held in between.
//  - Reset asserted on CALC cycle 2 -> next edge IDLE, oBusy=0, oDone=0, oResult=0;
//    a new start afterwards gives a correct product.
//  - WIDTH=16 random sweep (1000 vectors) vs A*B: latency 8 (fixed),
//    or <= 8 and equal to ceil(msb(B)/2) with MUL_EARLY_TERM_EN.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential radix-4 multiplier: FSM state
// encodings, the radix-4 digit width, and a helper that sizes the digit
// counter.
package mul_pkg;

    // Controller states; the encodings are fixed so that waveforms and
    // debug probes read the same across builds
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Each iteration retires one radix-4 digit, i.e. two multiplier bits
    localparam int DIGIT_W = 2;

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Counter width for a given digit count.  A single-digit operand would
    // need zero bits, so this never returns less than one bit.
    function automatic int cntWidth(input int digits);
        return (clog2(digits) < 1) ? 1 : clog2(digits);
    endfunction

endpackage

// File: rtl/radix4_digit_mux.sv
// Radix-4 partial-product selector: picks 0, A, 2A or 3A for one
// multiplier digit.  3A is supplied from outside because it needs an
// adder, and the caller computes it once per operation rather than on
// every iteration.
module radix4_digit_mux
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH+1:0]   a3_i,
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [WIDTH+1:0]   multiple_o
);

    // Select the multiple of A that corresponds to the current digit
    always_comb begin
        multiple_o = '0;
        case (digit_i)
            2'd0:    multiple_o = '0;
            2'd1:    multiple_o = {2'b00, a_i};
            2'd2:    multiple_o = {1'b0, a_i, 1'b0};
            default: multiple_o = a3_i;
        endcase
    end

endmodule

// File: rtl/seq_radix4_multiplier.sv
// Iterative unsigned WIDTH x WIDTH -> 2*WIDTH multiplier.  Two multiplier
// bits are retired per clock, so a full product takes WIDTH/2 cycles.
// Start/done handshake: a start is accepted only while idle or while the
// previous result is being presented, which allows back-to-back operations.
//
// Optional feature macro: MUL_EARLY_TERM_EN
//   When defined, the calculation also stops as soon as the remaining
//   multiplier bits are all zero, so small multipliers finish early.  The
//   product is unaffected because the skipped digits contribute nothing.
module seq_radix4_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iStart,
    input  logic [WIDTH-1:0]     iA,
    input  logic [WIDTH-1:0]     iB,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [2*WIDTH-1:0]   oResult
);

    localparam int N      = WIDTH / 2;
    localparam int CNT_W  = cntWidth(N);
    localparam int ACC_W  = 2 * WIDTH;
    localparam int MULT_W = WIDTH + 2;

    // Odd or tiny widths would leave a half digit with no defined meaning
    generate
        if (WIDTH < 2 || (WIDTH % 2) != 0) begin : gWidthCheck
            $error("seq_radix4_multiplier: WIDTH must be even and >= 2");
        end
    endgenerate

    state_e              stateQ, stateD;
    logic [WIDTH-1:0]    aQ, aD;
    logic [MULT_W-1:0]   a3Q, a3D;
    logic [WIDTH-1:0]    bRegQ, bRegD;
    logic [ACC_W-1:0]    accQ, accD;
    logic [CNT_W-1:0]    cntQ, cntD;
    logic [ACC_W-1:0]    resultQ, resultD;

    logic                accept;
    logic                lastDigit;
    logic [WIDTH-1:0]    bShifted;
    logic [MULT_W-1:0]   multiple;
    logic [ACC_W-1:0]    partial;
    logic [ACC_W-1:0]    accSum;

    // A start only counts when no calculation is in flight
    assign accept = iStart && ((stateQ == ST_IDLE) || (stateQ == ST_DONE));

    assign bShifted = bRegQ >> DIGIT_W;

`ifdef MUL_EARLY_TERM_EN
    assign lastDigit = (cntQ == CNT_W'(N - 1)) || (bShifted == '0);
`else
    assign lastDigit = (cntQ == CNT_W'(N - 1));
`endif

    radix4_digit_mux #(
        .WIDTH      (WIDTH)
    ) uDigitMux (
        .a_i        (aQ),
        .a3_i       (a3Q),
        .digit_i    (bRegQ[DIGIT_W-1:0]),
        .multiple_o (multiple)
    );

    // Align the selected multiple with the digit position and accumulate;
    // 2*WIDTH bits always hold the full product, so no carry is lost
    assign partial = ACC_W'(multiple) << {cntQ, 1'b0};
    assign accSum  = accQ + partial;

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateQ <= ST_IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            ST_IDLE: begin
                if (accept) stateD = ST_CALC;
            end
            ST_CALC: begin
                if (lastDigit) stateD = ST_DONE;
            end
            ST_DONE: begin
                stateD = accept ? ST_CALC : ST_IDLE;
            end
            default: stateD = ST_IDLE;
        endcase
    end

    // Status outputs decoded straight from the state
    always_comb begin
        oBusy = (stateQ == ST_CALC);
        oDone = (stateQ == ST_DONE);
    end

    // Datapath next-state: load operands on accept, iterate in CALC, and
    // capture the finished product only when leaving CALC so the previous
    // product stays visible during a new calculation
    always_comb begin
        aD      = aQ;
        a3D     = a3Q;
        bRegD   = bRegQ;
        accD    = accQ;
        cntD    = cntQ;
        resultD = resultQ;
        if (accept) begin
            aD    = iA;
            a3D   = MULT_W'(iA) + (MULT_W'(iA) << 1);
            bRegD = iB;
            accD  = '0;
            cntD  = '0;
        end else if (stateQ == ST_CALC) begin
            accD  = accSum;
            bRegD = bShifted;
            cntD  = cntQ + CNT_W'(1);
            if (lastDigit) begin
                resultD = accSum;
            end
        end
    end

    // Datapath registers; reset discards any partial calculation
    always_ff @(posedge Clock) begin
        if (Reset) begin
            aQ      <= '0;
            a3Q     <= '0;
            bRegQ   <= '0;
            accQ    <= '0;
            cntQ    <= '0;
            resultQ <= '0;
        end else begin
            aQ      <= aD;
            a3Q     <= a3D;
            bRegQ   <= bRegD;
            accQ    <= accD;
            cntQ    <= cntD;
            resultQ <= resultD;
        end
    end

    assign oResult = resultQ;

endmodule
